leitor_matricula: RTL and testbench

LEITOR_MATRICULA -- requirements
Module: leitor_matricula

---
 rtl/leitor_matricula.sv | 150 +++++++++++++++
 tb/tb_leitor_matricula.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/leitor_matricula.sv
// leitor_matricula: collects six hex plate digits and presents them as one plate.
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Digito/DigitoVal  incoming digit and its single-cycle strobe
//   Limpar            synchronous cancel of the entry in progress
//   Ack               validator has consumed the presented plate
//   A..F              presented plate (A first digit), updated only on completion
//   MatrPronta        plate on A..F awaiting Ack
//   Ocupado           digits are currently dropped (state decode)
//   Erro              one-cycle pulse on inter-digit timeout
//   DigitosRec        digits collected so far (0-6)
module leitor_matricula #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TW      = 10
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [3:0] Digito,
  input  logic       DigitoVal,
  input  logic       Limpar,
  input  logic       Ack,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [3:0] F,
  output logic       MatrPronta,
  output logic       Ocupado,
  output logic       Erro,
  output logic [2:0] DigitosRec
);

  localparam int unsigned DW    = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned NSLOT = 6;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NSLOT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOLHA = 2'd1,
    PRONTA  = 2'd2,
    ERRO    = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [NSLOT-1:0][DW-1:0]     buf_q, buf_d;
  logic [NSLOT-1:0][DW-1:0]     plate_q, plate_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [TW-1:0]                tmr_q, tmr_d;
  logic                         pronta_q, pronta_d;
  logic                         erro_q, erro_d;

  // State and datapath registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      plate_q  <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      pronta_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      plate_q  <= plate_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      pronta_q <= pronta_d;
      erro_q   <= erro_d;
    end
  end

  // Next-state and registered-output logic; Limpar overrides everything
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    plate_d  = plate_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    pronta_d = 1'b0;
    erro_d   = 1'b0;

    if (Limpar) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (DigitoVal) begin
            buf_d[0] = Digito;
            cnt_d    = CW'(1);
            tmr_d    = '0;
            state_d  = RECOLHA;
          end
        end
        RECOLHA: begin
          if (DigitoVal) begin
            buf_d[cnt_q] = Digito;
            cnt_d        = cnt_q + CW'(1);
            tmr_d        = '0;
            // Sixth digit: publish the whole buffer including this digit
            if (cnt_q == LAST_SLOT) begin
              plate_d  = buf_d;
              pronta_d = 1'b1;
              state_d  = PRONTA;
            end
          end else if (tmr_q == TMO_LAST) begin
            buf_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
            erro_d  = 1'b1;
            state_d = ERRO;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        PRONTA: begin
          pronta_d = 1'b1;
          if (Ack) begin
            pronta_d = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
          end
        end
        ERRO: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign A          = plate_q[0];
  assign B          = plate_q[1];
  assign C          = plate_q[2];
  assign D          = plate_q[3];
  assign E          = plate_q[4];
  assign F          = plate_q[5];
  assign MatrPronta = pronta_q;
  assign Erro       = erro_q;
  assign DigitosRec = cnt_q;
  assign Ocupado    = (state_q == PRONTA) || (state_q == ERRO);

endmodule

// File: tb/tb_leitor_matricula.sv
// Self-checking bench for leitor_matricula with a plate scoreboard.
module tb_leitor_matricula;

  localparam int unsigned TMO = 8;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [3:0] Digito;
  logic       DigitoVal, Limpar, Ack;
  logic [3:0] A, B, C, D, E, F;
  logic       MatrPronta, Ocupado, Erro;
  logic [2:0] DigitosRec;
  logic [23:0] plate;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_plate = '0;
  logic        prev_pronta = 1'b0;

  leitor_matricula #(.TIMEOUT(TMO), .TW(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Digito(Digito), .DigitoVal(DigitoVal),
    .Limpar(Limpar), .Ack(Ack), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
    .MatrPronta(MatrPronta), .Ocupado(Ocupado), .Erro(Erro),
    .DigitosRec(DigitosRec)
  );

  always #5 Clk = ~Clk;

  assign plate = {A, B, C, D, E, F};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: each rising MatrPronta must carry the oldest expected plate
  always @(negedge Clk) begin
    if (MatrPronta && !prev_pronta) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_plate", {8'h0, plate}, 32'hFFFF_FFFF);
      else check_eq("sb_plate", {8'h0, plate}, {8'h0, exp_q.pop_front()});
    end
    prev_pronta = MatrPronta;
  end

  task automatic step(input logic dv, input logic [3:0] d, input logic lim, input logic ack);
    DigitoVal = dv; Digito = d; Limpar = lim; Ack = ack;
    @(posedge Clk); #1;
    DigitoVal = 1'b0; Digito = '0; Limpar = 1'b0; Ack = 1'b0;
  endtask

  task automatic enter_plate(input logic [23:0] p);
    logic [23:0] v;
    v = p;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) exp_q.push_back(v);
      step(1'b1, v[23-4*i -: 4], 1'b0, 1'b0);
      if (i == 4) begin
        check_eq("partial_hidden", {8'h0, plate}, {8'h0, exp_plate});
        check_eq("cnt5", {29'h0, DigitosRec}, 32'd5);
      end
    end
    exp_plate = v;
    check_eq("pronta_after6", {31'h0, MatrPronta}, 32'd1);
    check_eq("cnt6", {29'h0, DigitosRec}, 32'd6);
    check_eq("ocupado_pronta", {31'h0, Ocupado}, 32'd1);
  endtask

  task automatic do_ack();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check_eq("ack_pronta_clr", {31'h0, MatrPronta}, 32'd0);
    check_eq("ack_cnt_clr", {29'h0, DigitosRec}, 32'd0);
    check_eq("ack_plate_held", {8'h0, plate}, {8'h0, exp_plate});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic err_seen;
    Rst_n = 1'b0; Digito = '0; DigitoVal = 1'b0; Limpar = 1'b0; Ack = 1'b0;
    #12;
    check_eq("rst_plate", {8'h0, plate}, 32'h0);
    check_eq("rst_pronta", {31'h0, MatrPronta}, 32'd0);
    check_eq("rst_cnt", {29'h0, DigitosRec}, 32'd0);
    check_eq("rst_ocupado", {31'h0, Ocupado}, 32'd0);
    check_eq("rst_erro", {31'h0, Erro}, 32'd0);
    Rst_n = 1'b1;

    // Back-to-back plate, first edge after reset accepts a digit
    enter_plate(24'h34A366);
    do_ack();

    // Digit dropped while a plate is presented
    enter_plate(24'hBBABFF);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    check_eq("drop_ocupado", {31'h0, Ocupado}, 32'd1);
    check_eq("drop_cnt", {29'h0, DigitosRec}, 32'd6);
    check_eq("drop_plate", {8'h0, plate}, {8'h0, exp_plate});
    do_ack();
    enter_plate(24'h123468);
    do_ack();

    // Timeout after the third digit
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      if (k < 8) begin
        check_eq("tmo_no_erro_yet", {31'h0, Erro}, 32'd0);
        check_eq("tmo_cnt_held", {29'h0, DigitosRec}, 32'd3);
      end
    end
    check_eq("tmo_erro", {31'h0, Erro}, 32'd1);
    check_eq("tmo_cnt_clr", {29'h0, DigitosRec}, 32'd0);
    check_eq("tmo_ocupado", {31'h0, Ocupado}, 32'd1);
    check_eq("tmo_plate_held", {8'h0, plate}, {8'h0, exp_plate});
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check_eq("tmo_erro_1cyc", {31'h0, Erro}, 32'd0);
    check_eq("tmo_back_idle", {31'h0, Ocupado}, 32'd0);

    // Digit on the 7th idle cycle, then on the last allowed cycle
    step(1'b1, 4'hB, 1'b0, 1'b0);
    step(1'b1, 4'hD, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    check_eq("idle7_accept", {29'h0, DigitosRec}, 32'd4);
    check_eq("idle7_no_erro", {31'h0, Erro}, 32'd0);
    for (int k = 0; k < TMO - 1; k++) step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    check_eq("edge_accept", {29'h0, DigitosRec}, 32'd5);
    check_eq("edge_no_erro", {31'h0, Erro}, 32'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_eq("limpar_clr", {29'h0, DigitosRec}, 32'd0);

    // Limpar with the sixth digit discards it
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b1, 1'b0);
    check_eq("lim6_cnt", {29'h0, DigitosRec}, 32'd0);
    check_eq("lim6_pronta", {31'h0, MatrPronta}, 32'd0);
    check_eq("lim6_erro", {31'h0, Erro}, 32'd0);
    check_eq("lim6_plate", {8'h0, plate}, {8'h0, exp_plate});
    err_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      err_seen |= Erro;
    end
    check_eq("idle_no_timer", {31'h0, err_seen}, 32'd0);

    // Limpar in the timeout cycle wins over Erro
    step(1'b1, 4'h7, 1'b0, 1'b0);
    for (int k = 0; k < TMO - 1; k++) step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check_eq("lim_tmo_erro", {31'h0, Erro}, 32'd0);
    check_eq("lim_tmo_idle", {31'h0, Ocupado}, 32'd0);

    // Ack in RECOLHA ignored; Ack+Limpar in PRONTA
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check_eq("ack_recolha_cnt", {29'h0, DigitosRec}, 32'd2);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    exp_q.push_back(24'h557712);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    exp_plate = 24'h557712;
    check_eq("mixed_pronta", {31'h0, MatrPronta}, 32'd1);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check_eq("acklim_pronta", {31'h0, MatrPronta}, 32'd0);
    check_eq("acklim_cnt", {29'h0, DigitosRec}, 32'd0);
    check_eq("acklim_idle", {31'h0, Ocupado}, 32'd0);
    check_eq("acklim_plate", {8'h0, plate}, {8'h0, exp_plate});

    // Asynchronous reset mid-entry
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 9), 1'b0, 1'b0);
    check_eq("pre_rst_cnt", {29'h0, DigitosRec}, 32'd4);
    #2 Rst_n = 1'b0;
    #1;
    check_eq("arst_plate", {8'h0, plate}, 32'h0);
    check_eq("arst_cnt", {29'h0, DigitosRec}, 32'd0);
    check_eq("arst_pronta", {31'h0, MatrPronta}, 32'd0);
    check_eq("arst_erro_ocup", {30'h0, Erro, Ocupado}, 32'd0);
    #2 Rst_n = 1'b1;
    exp_plate = '0;
    @(posedge Clk); #1;
    enter_plate(24'hC0FFEE);
    do_ack();

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
